wired_lsu_tag_writer: RTL

Single tag-SRAM write master for the LSU dcache. It arbitrates refill, write-permission-upgrade and full-cache flush requests, drives the tag SRAM write port, and broadcasts every tag write as a `dsram_snoop_t`. Store-buffer entries consume that broadcast to keep their per-way hit/writable bits coherent. It sits between the miss handler / cache-op unit and the dcache tag banks.

---
 rtl/wired_lsu_tag_writer_pkg.sv | 29 ++
 rtl/wired_lsu_tag_writer_if.sv | 36 +++
 rtl/wired_lsu_tag_wreg.sv | 30 +++
 rtl/wired_lsu_tag_writer.sv | 101 ++++++++++
 4 files changed

// File: rtl/wired_lsu_tag_writer_pkg.sv
// Shared dcache tag types and constants for the LSU tag-SRAM write path.
package wired_lsu_tag_writer_pkg;

  localparam int unsigned WAY_CNT  = 4;
  localparam int unsigned SET_BITS = 8;
  localparam int unsigned TAG_BITS = 20;

  typedef struct packed {
    logic [TAG_BITS-1:0] p;
    logic                wp;
    logic                v;
  } dtag_t;

  typedef struct packed {
    logic [11:0]        taddr;
    logic [WAY_CNT-1:0] twe;
    dtag_t              t;
  } dsram_snoop_t;

  typedef enum logic {
    TW_IDLE,
    TW_FLUSH
  } tw_state_e;

  function automatic logic [11:0] set_to_waddr(input logic [SET_BITS-1:0] set);
    return {set, 4'b0000};
  endfunction

endpackage

// File: rtl/wired_lsu_tag_writer_if.sv
// Request/response bundle between the miss handler, cache-op unit and the tag writer.
interface wired_lsu_tag_writer_if;
  import wired_lsu_tag_writer_pkg::*;

  logic                refill_valid_i;
  logic                refill_ready_o;
  logic [31:0]         refill_paddr_i;
  logic [WAY_CNT-1:0]  refill_way_i;
  logic                refill_wp_i;
  logic                upg_valid_i;
  logic                upg_ready_o;
  logic [31:0]         upg_paddr_i;
  logic [WAY_CNT-1:0]  upg_way_i;
  logic                flush_req_i;
  logic                flush_busy_o;
  logic                flush_done_o;
  logic [11:0]         tag_waddr_o;
  logic [WAY_CNT-1:0]  tag_we_o;
  dtag_t               tag_wdata_o;
  dsram_snoop_t        snoop_o;

  modport slave (
    input  refill_valid_i, refill_paddr_i, refill_way_i, refill_wp_i,
    input  upg_valid_i, upg_paddr_i, upg_way_i, flush_req_i,
    output refill_ready_o, upg_ready_o, flush_busy_o, flush_done_o,
    output tag_waddr_o, tag_we_o, tag_wdata_o, snoop_o
  );

  modport master (
    output refill_valid_i, refill_paddr_i, refill_way_i, refill_wp_i,
    output upg_valid_i, upg_paddr_i, upg_way_i, flush_req_i,
    input  refill_ready_o, upg_ready_o, flush_busy_o, flush_done_o,
    input  tag_waddr_o, tag_we_o, tag_wdata_o, snoop_o
  );

endinterface

// File: rtl/wired_lsu_tag_wreg.sv
// Tag write output register; one copy feeds both the SRAM port and the snoop broadcast.
module wired_lsu_tag_wreg
  import wired_lsu_tag_writer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [WAY_CNT-1:0] we_d,
  input  logic [11:0]        addr_d,
  input  dtag_t              data_d,
  output logic [WAY_CNT-1:0] we_q,
  output logic [11:0]        addr_q,
  output dtag_t              data_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= wr_en ? we_d : '0;
      if (wr_en) begin
        addr_q <= addr_d;
        data_q <= data_d;
      end
    end
  end

endmodule

// File: rtl/wired_lsu_tag_writer.sv
// Single tag-SRAM write master: arbitrates refill, upgrade and flush sweep writes
// and mirrors every write onto the store-buffer snoop bus.
module wired_lsu_tag_writer
  import wired_lsu_tag_writer_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  wired_lsu_tag_writer_if.slave bus
);

  tw_state_e           state_q, state_d;
  logic [SET_BITS-1:0] cnt_q, cnt_d;
  logic                done_q, done_d;

  logic                wr_en;
  logic [WAY_CNT-1:0]  wr_we;
  logic [11:0]         wr_addr;
  dtag_t               wr_data;

  logic [WAY_CNT-1:0]  we_q;
  logic [11:0]         addr_q;
  dtag_t               data_q;

  logic                unused_paddr_lsbs;
  assign unused_paddr_lsbs = ^{bus.refill_paddr_i[3:0], bus.upg_paddr_i[3:0]};

  // Flush request blocks both requesters in the very cycle it is seen.
  assign bus.refill_ready_o = (state_q == TW_IDLE) && !bus.flush_req_i;
  assign bus.upg_ready_o    = (state_q == TW_IDLE) && !bus.flush_req_i && !bus.refill_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_we   = '0;
    wr_addr = '0;
    wr_data = '0;
    unique case (state_q)
      TW_IDLE: begin
        if (bus.flush_req_i) begin
          state_d = TW_FLUSH;
          cnt_d   = '0;
        end else if (bus.refill_valid_i) begin
          wr_en   = 1'b1;
          wr_we   = bus.refill_way_i;
          wr_addr = set_to_waddr(bus.refill_paddr_i[11:4]);
          wr_data = '{p: bus.refill_paddr_i[31:12], wp: bus.refill_wp_i, v: 1'b1};
        end else if (bus.upg_valid_i) begin
          wr_en   = 1'b1;
          wr_we   = bus.upg_way_i;
          wr_addr = set_to_waddr(bus.upg_paddr_i[11:4]);
          wr_data = '{p: bus.upg_paddr_i[31:12], wp: 1'b1, v: 1'b1};
        end
      end
      TW_FLUSH: begin
        wr_en   = 1'b1;
        wr_we   = '1;
        wr_addr = set_to_waddr(cnt_q);
        cnt_d   = cnt_q + SET_BITS'(1);
        if (cnt_q == '1) begin
          state_d = TW_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = TW_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TW_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  wired_lsu_tag_wreg u_wreg (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .we_d   (wr_we),
    .addr_d (wr_addr),
    .data_d (wr_data),
    .we_q   (we_q),
    .addr_q (addr_q),
    .data_q (data_q)
  );

  assign bus.tag_we_o     = we_q;
  assign bus.tag_waddr_o  = addr_q;
  assign bus.tag_wdata_o  = data_q;
  assign bus.snoop_o      = '{taddr: addr_q, twe: we_q, t: data_q};
  assign bus.flush_busy_o = (state_q == TW_FLUSH);
  assign bus.flush_done_o = done_q;

endmodule
